display_timing_gen: RTL and testbench
=====================================

Name: display_timing_gen

Overview:
- Generates VGA 640x480@60 Hz raster timing: horizontal/vertical pixel counters, sync pulses and the active-video qualifier.
- Sits directly upstream of the icon and world-map pixel stages. They consume pixCol/pixRow; the colorizer/VGA pins consume hSync/vSync/videoOn.
- Counters advance only on pixTick, so the block runs from the 100 MHz system clock with a 25 MHz pixel enable.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hSync/vSync (0 = active-low)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- pixTick  input  1  pixel enable, one clk wide; counters advance only when high
- pixCol  output  10  current column, 0..H_TOTAL-1
- pixRow  output  10  current row, 0..V_TOTAL-1
- hSync  output  1  horizontal sync
- vSync  output  1  vertical sync
- videoOn  output  1  high when pixCol<H_ACTIVE and pixRow<V_ACTIVE
- frameStart  output  1  one-clk pulse when counters enter (0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of H params = 800; V_TOTAL = sum of V params = 525. All compares use 10-bit unsigned arithmetic.
- Interface: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset (reset=1 at a clk edge, overrides pixTick):
  - pixCol=H_TOTAL-1 (799), pixRow=V_TOTAL-1 (524)
  - hSync=vSync=~SYNC_ACTIVE, videoOn=0, frameStart=0
  - These values are exactly the decode of (799,524), so the first pixTick after reset wraps to (0,0) and starts a clean frame.
- Counter update on a clk edge with reset=0 and pixTick=1:
  - pixCol = (pixCol==H_TOTAL-1) ? 0 : pixCol+1
  - pixRow advances only when pixCol wraps: (pixRow==V_TOTAL-1) ? 0 : pixRow+1
  - Row/column wrap (799,524)->(0,0) occurs on a single tick.
- With pixTick=0: all counters and sync/video outputs hold; frameStart=0.
- Output registration:
  - hSync, vSync and videoOn are registers loaded from the decode of the next counter values.
  - They are therefore always coherent with pixCol/pixRow in the same cycle. Zero latency between counter and qualifiers.
- Decode windows:
  - hSync asserted for column in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [656,751]
  - vSync asserted for row in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] = [490,491]
  - videoOn = col<640 && row<480
- frameStart: 1 for exactly one clk, on the edge where counters load (0,0) with pixTick=1; 0 otherwise.
- Reset asserted mid-frame: the next edge forces the reset values regardless of pixTick. No partial sync pulse is extended.
- pixTick high on consecutive clks is legal; each high clk advances one pixel.

Optional Feature:
- Macro: DTG_ICON_ALIGN_EN
- Defined:
  - hSync, vSync and videoOn pass through one additional clk-register stage (reset values as above), delaying them one clk relative to pixCol/pixRow.
  - Purpose: match the registered one-cycle botIcon output of the icon stage.
  - frameStart and the counters are not delayed.
- Undefined: no extra stage; qualifiers are coherent with the counters as specified above.

Test Plan:
- Reset held 3 clks, then release with pixTick every 4th clk -> reset values (799,524,hSync=1,vSync=1,videoOn=0); first tick gives (0,0), videoOn=1, frameStart=1 for one clk.
- Run one full line -> pixCol 0..799 then 0; hSync low for exactly 96 ticks starting at col 656; videoOn low from col 640 to 799; pixRow increments to 1 on the wrap.
- Run one full frame (420000 ticks) -> vSync low for exactly 2 lines (rows 490,491, 1600 ticks); exactly one frameStart pulse per frame; wrap (799,524)->(0,0).
- Drop pixTick to 0 for 20 clks at col 700 -> all outputs frozen, including hSync=0; resumes at col 701.
- Assert reset for one clk at (300,200) with pixTick=1 -> next state (799,524), not (301,200); next tick (0,0) with frameStart=1.
- Compile with DTG_ICON_ALIGN_EN -> hSync falling edge seen one clk after pixCol becomes 656; videoOn rises one clk after (0,0); counters unchanged.

Source files
------------

// File: rtl/display_timing_gen.sv
// display_timing_gen: VGA raster timing (640x480@60 by default).
// Column/row counters advance on the pixel enable; sync and active-video
// qualifiers are registered from the decode of the next counter values, so
// they line up with pixCol/pixRow in the same cycle.
// Optional build macro: DTG_ICON_ALIGN_EN adds one clk of delay to
// hSync/vSync/videoOn to line up with the registered icon stage.
module display_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixTick,
  output logic [9:0] pixCol,
  output logic [9:0] pixRow,
  output logic       hSync,
  output logic       vSync,
  output logic       videoOn,
  output logic       frameStart
);

  localparam logic [9:0] H_TOTAL  = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] V_TOTAL  = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] H_LAST   = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST   = V_TOTAL - 10'd1;
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_OFF = ~SYNC_ACTIVE;

  logic [9:0] col_q, col_d;
  logic [9:0] row_q, row_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;
  logic       frame_q, frame_d;

  // Next counter values; row steps only when the column wraps.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixTick) begin
      if (col_q == H_LAST) begin
        col_d = 10'd0;
        row_d = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  // Qualifier decode of the next position; with no tick this reproduces
  // the current register contents, so everything holds.
  always_comb begin
    hsync_d = ((col_d >= HS_FIRST) && (col_d <= HS_LAST)) ? SYNC_ACTIVE : SYNC_OFF;
    vsync_d = ((row_d >= VS_FIRST) && (row_d <= VS_LAST)) ? SYNC_ACTIVE : SYNC_OFF;
    video_d = (col_d < H_ACT) && (row_d < V_ACT);
    frame_d = pixTick && (col_d == 10'd0) && (row_d == 10'd0);
  end

  // Counter and qualifier registers; reset parks at the last pixel so the
  // first tick lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= H_LAST;
      row_q   <= V_LAST;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      video_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      frame_q <= frame_d;
    end
  end

  assign pixCol     = col_q;
  assign pixRow     = row_q;
  assign frameStart = frame_q;

`ifdef DTG_ICON_ALIGN_EN
  logic hsync_dly_q, vsync_dly_q, video_dly_q;

  // Extra qualifier stage to match the icon stage's one-clk output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_dly_q <= SYNC_OFF;
      vsync_dly_q <= SYNC_OFF;
      video_dly_q <= 1'b0;
    end else begin
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
      video_dly_q <= video_q;
    end
  end

  assign hSync   = hsync_dly_q;
  assign vSync   = vsync_dly_q;
  assign videoOn = video_dly_q;
`else
  assign hSync   = hsync_q;
  assign vSync   = vsync_q;
  assign videoOn = video_q;
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a default 640x480 instance plus a tiny
// instance (opposite sync polarity) so whole frames fit in a short run.
// The model tracks a linear pixel index and derives col/row/sync by division.
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pixTick = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] col_w[2];
  logic [9:0] row_w[2];
  logic       hs_w[2], vs_w[2], vo_w[2], fs_w[2];

  display_timing_gen u_big (
    .clk(clk), .reset(reset), .pixTick(pixTick),
    .pixCol(col_w[0]), .pixRow(row_w[0]),
    .hSync(hs_w[0]), .vSync(vs_w[0]), .videoOn(vo_w[0]), .frameStart(fs_w[0])
  );

  display_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b1)
  ) u_small (
    .clk(clk), .reset(reset), .pixTick(pixTick),
    .pixCol(col_w[1]), .pixRow(row_w[1]),
    .hSync(hs_w[1]), .vSync(vs_w[1]), .videoOn(vo_w[1]), .frameStart(fs_w[1])
  );

  int HA[2] = '{640, 8};
  int HF[2] = '{16, 2};
  int HS[2] = '{96, 3};
  int HB[2] = '{48, 2};
  int VA[2] = '{480, 6};
  int VF[2] = '{10, 2};
  int VS[2] = '{2, 2};
  int VB[2] = '{33, 3};
  bit SA[2] = '{1'b0, 1'b1};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int htot(input int d);
    return HA[d] + HF[d] + HS[d] + HB[d];
  endfunction
  function automatic int vtot(input int d);
    return VA[d] + VF[d] + VS[d] + VB[d];
  endfunction

  // {hSync, vSync, videoOn} for pixel index pp
  function automatic logic [2:0] dec(input int d, input int pp);
    int c, r;
    logic [2:0] o;
    c = pp % htot(d);
    r = pp / htot(d);
    o[2] = (c >= HA[d] + HF[d] && c < HA[d] + HF[d] + HS[d]) ? SA[d] : !SA[d];
    o[1] = (r >= VA[d] + VF[d] && r < VA[d] + VF[d] + VS[d]) ? SA[d] : !SA[d];
    o[0] = (c < HA[d]) && (r < VA[d]);
    return o;
  endfunction

  // Model state: linear pixel index per instance
  int         p[2] = '{0, 0};
  bit         fs_m[2];
  logic [2:0] dprev[2];
  bit         mvalid = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      dprev[d] = reset ? {!SA[d], !SA[d], 1'b0} : dec(d, p[d]);
      if (reset) p[d] = htot(d) * vtot(d) - 1;
      else if (pixTick) p[d] = (p[d] + 1) % (htot(d) * vtot(d));
      fs_m[d] = !reset && pixTick && (p[d] == 0);
    end
    if (reset) mvalid = 1'b1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (mvalid) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0] e;
`ifdef DTG_ICON_ALIGN_EN
        e = dprev[d];
`else
        e = dec(d, p[d]);
`endif
        chk($sformatf("col[%0d]", d), int'(col_w[d]), p[d] % htot(d));
        chk($sformatf("row[%0d]", d), int'(row_w[d]), p[d] / htot(d));
        chk($sformatf("hsync[%0d]", d), int'(hs_w[d]), int'(e[2]));
        chk($sformatf("vsync[%0d]", d), int'(vs_w[d]), int'(e[1]));
        chk($sformatf("videoOn[%0d]", d), int'(vo_w[d]), int'(e[0]));
        chk($sformatf("frameStart[%0d]", d), int'(fs_w[d]), int'(fs_m[d]));
      end
    end
  end

  task automatic step(input bit t, input bit r);
    pixTick = t;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_low;
    bit hit;
`ifdef DTG_ICON_ALIGN_EN
    bit align = 1'b1;
`else
    bit align = 1'b0;
`endif

    // Reset held three clks
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    @(negedge clk);
    chk("rst_col", int'(col_w[0]), 799);
    chk("rst_row", int'(row_w[0]), 524);
    chk("rst_hs", int'(hs_w[0]), 1);
    chk("rst_vs", int'(vs_w[0]), 1);
    chk("rst_vo", int'(vo_w[0]), 0);
    chk("rst_fs", int'(fs_w[0]), 0);
    chk("rst_small_col", int'(col_w[1]), 14);
    chk("rst_small_hs", int'(hs_w[1]), 0);

    // Tick every 4th clk
    for (int i = 0; i < 12; i++) begin
      step(i % 4 == 3, 1'b0);
      if (i == 3) begin
        @(negedge clk);
        chk("first_col", int'(col_w[0]), 0);
        chk("first_row", int'(row_w[0]), 0);
        chk("first_fs", int'(fs_w[0]), 1);
        chk("first_vo", int'(vo_w[0]), align ? 0 : 1);
      end
      if (i == 4) begin
        @(negedge clk);
        chk("fs_one_clk", int'(fs_w[0]), 0);
        chk("vo_after", int'(vo_w[0]), 1);
      end
    end

    // Continuous ticks across line 0 up to (700,1)
    hs_low = 0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step(1'b1, 1'b0);
      @(negedge clk);
      if (row_w[0] == 10'd0 && hs_w[0] == 1'b0) hs_low++;
      if (row_w[0] == 10'd0 && col_w[0] == 10'd656) chk("hs_at_656", int'(hs_w[0]), align ? 1 : 0);
      if (row_w[0] == 10'd0 && col_w[0] == 10'd657) chk("hs_at_657", int'(hs_w[0]), 0);
      if (row_w[0] == 10'd1 && col_w[0] == 10'd700) hit = 1'b1;
    end
    chk("reach_700", int'(hit), 1);
    chk("hs_low_ticks", hs_low, 96);

    // Freeze 20 clks inside the sync pulse
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    @(negedge clk);
    chk("frz_col", int'(col_w[0]), 700);
    chk("frz_row", int'(row_w[0]), 1);
    chk("frz_hs", int'(hs_w[0]), 0);
    step(1'b1, 1'b0);
    @(negedge clk);
    chk("resume_col", int'(col_w[0]), 701);

    // Mid-frame reset with tick high
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      step(1'b1, 1'b0);
      if (col_w[0] == 10'd300) hit = 1'b1;
    end
    chk("reach_300", int'(hit), 1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("mrst_col", int'(col_w[0]), 799);
    chk("mrst_row", int'(row_w[0]), 524);
    chk("mrst_hs", int'(hs_w[0]), 1);
    step(1'b1, 1'b0);
    @(negedge clk);
    chk("mrst_wrap_col", int'(col_w[0]), 0);
    chk("mrst_wrap_fs", int'(fs_w[0]), 1);

    // Randomized ticks with rare resets; the small instance wraps many frames
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1999) == 0);
    step(1'b0, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
